// File: rtl/pi_bus_capture_if.sv
// pi_bus_capture_if: PI cartridge bus pins plus the decoded event/address
// outputs of pi_bus_capture.
//   master : drives the raw PI pins (ad, aleh, alel, read, write) and
//            observes the decoded outputs
//   slave  : pi_bus_capture side, samples the pins and drives the outputs
// Optional: PI_ERR_COUNT_EN adds the 8-bit err_count signal.
interface pi_bus_capture_if #(
  parameter int unsigned INC_W = 13
);
  logic [15:0]      ad;
  logic             aleh;
  logic             alel;
  logic             read;
  logic             write;
  logic [31:0]      bus_addr;
  logic [31:0]      word_addr;
  logic [INC_W-1:0] inc_count;
  logic             addr_valid;
  logic             rd_start;
  logic             rd_end;
  logic             wr_strobe;
  logic [15:0]      wr_data;
  logic             wr_end;
  logic             err_overlap;
`ifdef PI_ERR_COUNT_EN
  logic [7:0]       err_count;
`endif

  modport master (
    output ad, aleh, alel, read, write,
`ifdef PI_ERR_COUNT_EN
    input  err_count,
`endif
    input  bus_addr, word_addr, inc_count, addr_valid, rd_start, rd_end,
           wr_strobe, wr_data, wr_end, err_overlap
  );

  modport slave (
    input  ad, aleh, alel, read, write,
`ifdef PI_ERR_COUNT_EN
    output err_count,
`endif
    output bus_addr, word_addr, inc_count, addr_valid, rd_start, rd_end,
           wr_strobe, wr_data, wr_end, err_overlap
  );
endinterface

// File: rtl/pi_bus_capture.sv
// pi_bus_capture: N64 PI bus front-end. Synchronises ALE_H/ALE_L//RD//WR,
// delays AD by the same number of stages, assembles the 32-bit bus address,
// tracks the burst word offset and emits single-cycle read/write strobes.
// Ports:
//   clk        system clock
//   cold_reset asynchronous active-high reset
//   bus        pi_bus_capture_if.slave (pins in, decoded outputs out)
// Optional feature macro: PI_ERR_COUNT_EN enables the saturating err_count
// (overlap cycles and aborted address phases).
module pi_bus_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INC_W       = 13
) (
  input  logic            clk,
  input  logic            cold_reset,
  pi_bus_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR_H, ADDR_L, DATA} state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_aleh_sync, r_alel_sync, r_rd_sync, r_wr_sync;
  logic [15:0]            r_ad_sync [SYNC_STAGES];
  logic                   r_aleh_d, r_alel_d, r_rd_d, r_wr_d;

  logic        w_s_aleh, w_s_alel, w_s_rd, w_s_wr;
  logic [15:0] w_s_ad;
  logic        w_aleh_rise, w_alel_fall, w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic        w_in_data, w_overlap;
  logic        w_hi_load, w_lo_load, w_enter_data, w_abort;
  logic [31:0] w_inc_x2;

  logic [31:0]      r_bus_addr, r_word_addr;
  logic [INC_W-1:0] r_inc_count;
  logic             r_addr_valid;
  logic             r_rd_start, r_rd_end, r_wr_strobe, r_wr_end, r_err_overlap;
  logic [15:0]      r_wr_data;

  assign w_s_aleh = r_aleh_sync[SYNC_STAGES-1];
  assign w_s_alel = r_alel_sync[SYNC_STAGES-1];
  assign w_s_rd   = r_rd_sync[SYNC_STAGES-1];
  assign w_s_wr   = r_wr_sync[SYNC_STAGES-1];
  assign w_s_ad   = r_ad_sync[SYNC_STAGES-1];

  assign w_aleh_rise = w_s_aleh & ~r_aleh_d;
  assign w_alel_fall = ~w_s_alel & r_alel_d;
  assign w_rd_fall   = ~w_s_rd & r_rd_d;
  assign w_rd_rise   = w_s_rd & ~r_rd_d;
  assign w_wr_fall   = ~w_s_wr & r_wr_d;
  assign w_wr_rise   = w_s_wr & ~r_wr_d;

  assign w_in_data = (r_state == DATA);
  assign w_overlap = w_in_data & ~w_s_rd & ~w_s_wr;
  assign w_inc_x2  = 32'({r_inc_count, 1'b0});

  // Strobe sides (/RD, /WR) reset to 1 so a pin held low across reset
  // release looks like a fresh fall, which is ignored outside DATA.
  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset) begin
      r_aleh_sync <= '0;
      r_alel_sync <= '0;
      r_rd_sync   <= '1;
      r_wr_sync   <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_ad_sync[i] <= '0;
      r_aleh_d <= 1'b0;
      r_alel_d <= 1'b0;
      r_rd_d   <= 1'b1;
      r_wr_d   <= 1'b1;
    end else begin
      r_aleh_sync[0] <= bus.aleh;
      r_alel_sync[0] <= bus.alel;
      r_rd_sync[0]   <= bus.read;
      r_wr_sync[0]   <= bus.write;
      r_ad_sync[0]   <= bus.ad;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_aleh_sync[i] <= r_aleh_sync[i-1];
        r_alel_sync[i] <= r_alel_sync[i-1];
        r_rd_sync[i]   <= r_rd_sync[i-1];
        r_wr_sync[i]   <= r_wr_sync[i-1];
        r_ad_sync[i]   <= r_ad_sync[i-1];
      end
      r_aleh_d <= w_s_aleh;
      r_alel_d <= w_s_alel;
      r_rd_d   <= w_s_rd;
      r_wr_d   <= w_s_wr;
    end
  end

  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hi_load    = 1'b0;
    w_lo_load    = 1'b0;
    w_enter_data = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_s_aleh && w_s_alel) w_state_next = ADDR_H;
      end
      ADDR_H: begin
        if (w_s_aleh && w_s_alel) begin
          w_hi_load = 1'b1;
        end else if (w_s_alel) begin
          w_state_next = ADDR_L;
        end else if (!w_s_aleh) begin
          w_state_next = IDLE;
          w_abort      = 1'b1;
        end
      end
      ADDR_L: begin
        if (w_aleh_rise) begin
          w_state_next = ADDR_H;
        end else if (w_alel_fall) begin
          w_state_next = DATA;
          w_enter_data = 1'b1;
        end else if (w_s_alel && !w_s_aleh) begin
          w_lo_load = 1'b1;
        end
      end
      DATA: begin
        if (w_aleh_rise) w_state_next = ADDR_H;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset) begin
      r_bus_addr    <= '0;
      r_word_addr   <= '0;
      r_inc_count   <= '0;
      r_addr_valid  <= 1'b0;
      r_rd_start    <= 1'b0;
      r_rd_end      <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_wr_end      <= 1'b0;
      r_err_overlap <= 1'b0;
      r_wr_data     <= '0;
    end else begin
      if (w_hi_load) r_bus_addr[31:16] <= w_s_ad;
      if (w_lo_load) r_bus_addr[15:0]  <= w_s_ad;

      if (w_aleh_rise)       r_addr_valid <= 1'b0;
      else if (w_enter_data) r_addr_valid <= 1'b1;

      // A rise of both strobes in one cycle still counts as one word.
      if (w_aleh_rise || w_enter_data)
        r_inc_count <= '0;
      else if (w_in_data && (w_rd_rise || w_wr_rise))
        r_inc_count <= r_inc_count + INC_W'(1);

      r_word_addr   <= r_bus_addr + w_inc_x2;
      r_rd_start    <= w_in_data & w_rd_fall;
      r_rd_end      <= w_in_data & w_rd_rise;
      r_wr_strobe   <= w_in_data & w_wr_fall;
      r_wr_end      <= w_in_data & w_wr_rise;
      r_err_overlap <= w_overlap;
      if (w_in_data && w_wr_fall) r_wr_data <= w_s_ad;
    end
  end

`ifdef PI_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge cold_reset) begin
    if (cold_reset)
      r_err_count <= '0;
    else if ((w_overlap || w_abort) && (r_err_count != 8'hFF))
      r_err_count <= r_err_count + 8'd1;
  end

  assign bus.err_count = r_err_count;
`endif

  assign bus.bus_addr    = r_bus_addr;
  assign bus.word_addr   = r_word_addr;
  assign bus.inc_count   = r_inc_count;
  assign bus.addr_valid  = r_addr_valid;
  assign bus.rd_start    = r_rd_start;
  assign bus.rd_end      = r_rd_end;
  assign bus.wr_strobe   = r_wr_strobe;
  assign bus.wr_data     = r_wr_data;
  assign bus.wr_end      = r_wr_end;
  assign bus.err_overlap = r_err_overlap;

endmodule

// File: tb/tb_pi_bus_capture.sv
// tb_pi_bus_capture: drives PI bus transactions into two pi_bus_capture
// instances sharing the same pins (INC_W=13 and INC_W=3) and compares their
// outputs with a transaction-level model of the PI capture rules.
// Optional feature macro: PI_ERR_COUNT_EN (err_count checks).
module tb_pi_bus_capture;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        cold_reset;
  logic [15:0] ad;
  logic        aleh, alel, read, write;

  always #5 clk = ~clk;

  pi_bus_capture_if #(.INC_W(13)) bus13 ();
  pi_bus_capture_if #(.INC_W(3))  bus3 ();

  assign bus13.ad    = ad;
  assign bus13.aleh  = aleh;
  assign bus13.alel  = alel;
  assign bus13.read  = read;
  assign bus13.write = write;
  assign bus3.ad     = ad;
  assign bus3.aleh   = aleh;
  assign bus3.alel   = alel;
  assign bus3.read   = read;
  assign bus3.write  = write;

  pi_bus_capture #(.SYNC_STAGES(SYNC), .INC_W(13)) u_dut (
    .clk        (clk),
    .cold_reset (cold_reset),
    .bus        (bus13.slave)
  );

  pi_bus_capture #(.SYNC_STAGES(SYNC), .INC_W(3)) u_dut_w3 (
    .clk        (clk),
    .cold_reset (cold_reset),
    .bus        (bus3.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // observed pulse counts (main instance)
  int          n_rd_start = 0, n_rd_end = 0, n_wr_strobe = 0, n_wr_end = 0, n_overlap = 0;
  logic [15:0] seen_wr_data = '0;

  // model state
  logic [31:0] m_base;
  int unsigned m_cnt;
  logic        m_valid;
  logic [15:0] m_wr_data;
  int          m_rd_start, m_rd_end, m_wr_strobe, m_wr_end, m_overlap;
  int unsigned m_err;

  always @(negedge clk) begin
    if (bus13.rd_start)    n_rd_start++;
    if (bus13.rd_end)      n_rd_end++;
    if (bus13.wr_strobe) begin
      n_wr_strobe++;
      seen_wr_data = bus13.wr_data;
    end
    if (bus13.wr_end)      n_wr_end++;
    if (bus13.err_overlap) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_base    = '0;
    m_cnt     = 0;
    m_valid   = 1'b0;
    m_wr_data = '0;
    m_err     = 0;
  endtask

  task automatic err_bump(input int unsigned k);
    m_err = (m_err + k > 255) ? 255 : m_err + k;
  endtask

  task automatic check_state(input string ctx);
    int unsigned off13, off3;
    off13 = m_cnt % 8192;
    off3  = m_cnt % 8;
    check({ctx, ".bus_addr"},    bus13.bus_addr, m_base);
    check({ctx, ".word_addr"},   bus13.word_addr, m_base + 32'(off13 * 2));
    check({ctx, ".inc_count"},   32'(bus13.inc_count), 32'(off13));
    check({ctx, ".addr_valid"},  32'(bus13.addr_valid), 32'(m_valid));
    check({ctx, ".wr_data"},     32'(bus13.wr_data), 32'(m_wr_data));
    check({ctx, ".n_rd_start"},  32'(n_rd_start), 32'(m_rd_start));
    check({ctx, ".n_rd_end"},    32'(n_rd_end), 32'(m_rd_end));
    check({ctx, ".n_wr_strobe"}, 32'(n_wr_strobe), 32'(m_wr_strobe));
    check({ctx, ".n_wr_end"},    32'(n_wr_end), 32'(m_wr_end));
    check({ctx, ".n_overlap"},   32'(n_overlap), 32'(m_overlap));
    check({ctx, ".w3.inc"},      32'(bus3.inc_count), 32'(off3));
    check({ctx, ".w3.word"},     bus3.word_addr, m_base + 32'(off3 * 2));
`ifdef PI_ERR_COUNT_EN
    check({ctx, ".err_count"},   32'(bus13.err_count), m_err);
`endif
  endtask

  task automatic addr_phase(input logic [15:0] hi, input logic [15:0] lo);
    aleh = 1'b1; alel = 1'b1; ad = hi;
    idle(6);
    aleh = 1'b0; ad = lo;
    idle(6);
    alel = 1'b0;
    idle(6);
    m_base  = {hi, lo};
    m_cnt   = 0;
    m_valid = 1'b1;
  endtask

  task automatic rd_op();
    read = 1'b0; idle(4);
    read = 1'b1; idle(4);
    if (m_valid) begin
      m_cnt++; m_rd_start++; m_rd_end++;
    end
  endtask

  task automatic wr_op(input logic [15:0] data);
    ad = data; idle(4);
    write = 1'b0; idle(4);
    write = 1'b1; idle(4);
    if (m_valid) begin
      m_cnt++; m_wr_strobe++; m_wr_end++;
      m_wr_data = data;
      check("wr_strobe_data", 32'(seen_wr_data), 32'(data));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    m_rd_start = 0; m_rd_end = 0; m_wr_strobe = 0; m_wr_end = 0; m_overlap = 0;
    model_reset();
    cold_reset = 1'b1;
    ad = '0; aleh = 1'b0; alel = 1'b0; read = 1'b1; write = 1'b1;
    idle(3);
    check_state("reset");
    cold_reset = 1'b0;
    idle(4);

    // aborted address phase: ALE_H+ALE_L then both low together
    aleh = 1'b1; alel = 1'b1; ad = 16'h1234;
    idle(6);
    aleh = 1'b0; alel = 1'b0;
    idle(6);
    err_bump(1);
    check("abort.addr_valid", 32'(bus13.addr_valid), 32'd0);
    check("abort.n_rd_start", 32'(n_rd_start), 32'd0);

    // address phase and 4-read burst; first read also measures latency
    addr_phase(16'h1EC0, 16'h0010);
    check_state("addr");
    read = 1'b0;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus13.rd_start && first == 0) first = k;
    end
    read = 1'b1; idle(4);
    m_cnt++; m_rd_start++; m_rd_end++;
    check("rd_latency", 32'(first), 32'(SYNC + 1));
    for (int i = 0; i < 3; i++) rd_op();
    check_state("burst4");
    check("burst4.word", bus13.word_addr, 32'h1EC0_0018);

    // single write
    addr_phase(16'h1040, 16'h0400);
    wr_op(16'h001E);
    check_state("write");
    check("write.inc", 32'(bus13.inc_count), 32'd1);

    // new address mid-burst, with a stray /RD pulse during the address phase
    addr_phase(16'h0ABC, 16'h0DEF);
    for (int i = 0; i < 3; i++) rd_op();
    aleh = 1'b1; alel = 1'b1; ad = 16'h3000;
    idle(6);
    m_valid = 1'b0; m_cnt = 0;
    check("midaddr.addr_valid", 32'(bus13.addr_valid), 32'd0);
    check("midaddr.inc", 32'(bus13.inc_count), 32'd0);
    rd_op();
    check("midaddr.n_rd_start", 32'(n_rd_start), 32'(m_rd_start));
    check("midaddr.n_rd_end", 32'(n_rd_end), 32'(m_rd_end));
    aleh = 1'b0; ad = 16'h0040;
    idle(6);
    alel = 1'b0;
    idle(6);
    m_base = 32'h3000_0040; m_valid = 1'b1;
    rd_op();
    check_state("midaddr.resume");

    // wrap of the 3-bit counter instance
    addr_phase(16'h2000, 16'h0100);
    for (int i = 0; i < 9; i++) rd_op();
    check_state("wrap");
    check("wrap.w3.word", bus3.word_addr, 32'h2000_0102);

    // randomized bursts
    for (int b = 0; b < 20; b++) begin
      int len;
      addr_phase(16'($urandom), 16'($urandom));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 0) rd_op();
        else                           wr_op(16'($urandom));
      end
      check_state("rand");
    end

    // overlap: /RD and /WR low together for 3 cycles, then reset with /RD low
    addr_phase(16'h1FD0, 16'h0000);
    ad = 16'hBEEF; idle(4);
    read = 1'b0; write = 1'b0;
    idle(3);
    write = 1'b1;
    idle(6);
    m_rd_start++; m_wr_strobe++; m_wr_end++; m_cnt++;
    m_wr_data = 16'hBEEF;
    m_overlap += 3;
    err_bump(3);
    check_state("overlap");

    #2 cold_reset = 1'b1;
    #1;
    model_reset();
    check("rst.bus_addr",   bus13.bus_addr, 32'd0);
    check("rst.word_addr",  bus13.word_addr, 32'd0);
    check("rst.inc",        32'(bus13.inc_count), 32'd0);
    check("rst.addr_valid", 32'(bus13.addr_valid), 32'd0);
    check("rst.wr_data",    32'(bus13.wr_data), 32'd0);
    check("rst.pulses",     32'({bus13.rd_start, bus13.rd_end, bus13.wr_strobe,
                                 bus13.wr_end, bus13.err_overlap}), 32'd0);
`ifdef PI_ERR_COUNT_EN
    check("rst.err_count",  32'(bus13.err_count), 32'd0);
`endif
    idle(2);
    cold_reset = 1'b0;
    idle(8);
    check_state("post_reset");
    read = 1'b1;
    idle(6);
    check_state("post_reset.rd_rise");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
